// File: rtl/condlogic.sv
// -----------------------------------------------------------------------------
// condlogic -- conditional-execution unit of a multicycle ARM-style core.
//
// It holds the architectural flag register {N,Z,C,V}. It evaluates the
// instruction's condition field against the flags that are currently
// registered. It then gates the flag, register, memory and PC write enables
// with the result of that evaluation.
//
// The gated write enables use the condition result registered on the
// previous edge (cond_ex_delayed_q). This gives the main FSM one cycle of
// latency between evaluating a condition and committing the instruction.
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   synchronous, active-high reset
//   Cond      in   [3:0] instruction condition field (instr[31:28])
//   ALUFlags  in   [3:0] ALU result flags {N,Z,C,V}
//   FlagW     in   [1:0] flag-write request: [1] = NZ update, [0] = CV update
//   PCS       in   instruction writes the PC (branch or write to R15)
//   NextPC    in   unconditional PC advance request from the main FSM
//   RegW      in   register-write request from the main FSM
//   MemW      in   memory-write request from the main FSM
//   PCWrite   out  gated PC write enable
//   RegWrite  out  gated register-file write enable
//   MemWrite  out  gated memory write enable
//   Flags     out  [3:0] architectural flag register {N,Z,C,V}
//
// Configuration
//   COND_NV_NEVER_EN  When defined, Cond=1111 (NV) never executes.
//                     When undefined (the default), NV behaves exactly like AL.
// -----------------------------------------------------------------------------
module condlogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q, cond_ex_delayed_d;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       flag_n, flag_z, flag_c, flag_v;

  // The condition is evaluated against the registered flags only. This means
  // a flag update in this cycle is seen by the next instruction, not this one.
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // an uncovered path can never infer a latch.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_e'(Cond))
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = flag_c & ~flag_z;
      COND_LS: cond_ex = ~flag_c | flag_z;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex = 1'b1;
`ifdef COND_NV_NEVER_EN
      COND_NV: cond_ex = 1'b0;
`else
      COND_NV: cond_ex = 1'b1;
`endif
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {cond_ex, cond_ex};

  // The NZ half and the CV half update independently. For example, a logical
  // op with FlagW=10 keeps the carry and overflow produced by an earlier op.
  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  assign cond_ex_delayed_d = cond_ex;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset wins over a simultaneous flag write and drops any pending commit.
      flags_q           <= 4'b0000;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  assign Flags    = flags_q;
  assign RegWrite = RegW & cond_ex_delayed_q;
  assign MemWrite = MemW & cond_ex_delayed_q;
  // NextPC is the FSM's fetch-stage advance, so it must never be gated.
  assign PCWrite  = NextPC | (PCS & cond_ex_delayed_q);

endmodule

// File: tb/tb_condlogic.sv
// -----------------------------------------------------------------------------
// tb_condlogic -- self-checking bench for condlogic.
// The bench runs directed scenarios for reset, AL, partial update, gating,
// branch and NV, then randomized cycles. All of these are checked against a
// behavioural model of the flag register and the commit latency.
// -----------------------------------------------------------------------------
module tb_condlogic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: the four flags as separate bits, and the condition
  // verdict that is waiting to be committed.
  bit m_n, m_z, m_c, m_v;
  bit m_pending;
  bit m_valid = 1'b0;

  condlogic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Even codes name a predicate and odd codes name its complement. NV is the
  // exception and depends on the build option.
  function automatic bit model_pass(input logic [3:0] c);
    bit p;
    if (c == 4'hF) begin
`ifdef COND_NV_NEVER_EN
      return 1'b0;
`else
      return 1'b1;
`endif
    end
    case (c[3:1])
      3'd0:    p = m_z;
      3'd1:    p = m_c;
      3'd2:    p = m_n;
      3'd3:    p = m_v;
      3'd4:    p = m_c && !m_z;
      3'd5:    p = (m_n == m_v);
      3'd6:    p = !m_z && (m_n == m_v);
      default: p = 1'b1;
    endcase
    return p ^ c[0];
  endfunction

  // Drives one cycle's inputs shortly after the falling edge. It then checks
  // the write enables and the flags against the model before the rising edge.
  task automatic apply(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic npc,
                       input logic rw, input logic mw);
    reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
    #1;
    if (m_valid) begin
      check("model_flags",    Flags,           {m_n, m_z, m_c, m_v});
      check("model_regwrite", {3'b0, RegWrite}, {3'b0, rw & m_pending});
      check("model_memwrite", {3'b0, MemWrite}, {3'b0, mw & m_pending});
      check("model_pcwrite",  {3'b0, PCWrite},  {3'b0, npc | (pcs & m_pending)});
    end
  endtask

  // Advances one rising edge and moves the model to the state after that edge.
  task automatic tick();
    bit pass;
    @(posedge clk);
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_pending = 1'b0;
      m_valid   = 1'b1;
    end else begin
      pass = model_pass(Cond);
      if (pass && FlagW[1]) {m_n, m_z} = ALUFlags[3:2];
      if (pass && FlagW[0]) {m_c, m_v} = ALUFlags[1:0];
      m_pending = pass;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] nv_exp;
    @(negedge clk);

    // Reset, then check the first cycle after reset.
    apply(1, 4'hE, 4'hF, 2'b11, 1, 0, 1, 1); tick();
    apply(0, 4'hE, 4'h0, 2'b00, 1, 0, 1, 1);
    check("rst_flags",    Flags,            4'b0000);
    check("rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("rst_memwrite", {3'b0, MemWrite}, 4'b0000);
    check("rst_pcwrite",  {3'b0, PCWrite},  4'b0000);
    tick();

    // AL update, then EQ sees Z=1, then the register write commits.
    apply(0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
    check("al_flags", Flags, 4'b0110);
    tick();
    apply(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
    check("eq_regwrite", {3'b0, RegWrite}, 4'b0001);
    tick();

    // An NZ-only update keeps C and V.
    apply(0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0); tick();
    apply(0, 4'h3, 4'hA, 2'b00, 0, 0, 0, 0);
    check("partial_flags", Flags, 4'b0011);
    tick();

    // A failing GE blocks both the flag write and the commit.
    apply(0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'hA, 4'b0100, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1);
    check("ge_flags",    Flags,            4'b1000);
    check("ge_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("ge_memwrite", {3'b0, MemWrite}, 4'b0000);
    tick();

    // NE with Z=1: the branch is dropped unless NextPC forces it.
    apply(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0); tick();
    apply(0, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0);
    check("ne_pcwrite",      {3'b0, PCWrite}, 4'b0000);
    apply(0, 4'h1, 4'h0, 2'b00, 1, 1, 0, 0);
    check("ne_nextpc_write", {3'b0, PCWrite}, 4'b0001);
    tick();

    // Reset has priority over a simultaneous flag write.
    apply(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    check("rst_priority", Flags, 4'b0000);
    tick();

    // NV from Flags=0000 with a full flag write.
`ifdef COND_NV_NEVER_EN
    nv_exp = 4'b0000;
`else
    nv_exp = 4'b1111;
`endif
    apply(0, 4'hF, 4'hF, 2'b11, 0, 0, 0, 0); tick();
    apply(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1);
    check("nv_flags",    Flags,            nv_exp);
    check("nv_regwrite", {3'b0, RegWrite}, {3'b0, nv_exp[0]});
    tick();

    // Randomized cycles, with reset asserted occasionally.
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 24) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
